imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 85 ++++++++
 tb/tb_imm_extend_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate extender feeding a small FIFO output buffer.
// The extended value is formed combinationally and captured on push; the head entry drives the output.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  immediate,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] extended,
    output logic [CW-1:0]    count
);

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [OUT_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_val;
    logic             push;
    logic             pop;

    always_comb begin
        sext = {{(OUT_W-IN_W){immediate[IN_W-1]}}, immediate};
        ext_val = '0;
        case (mode)
            2'b00: ext_val = {{(OUT_W-IN_W){1'b0}}, immediate};
            2'b01: ext_val = sext;
            2'b10: ext_val = {immediate, {(OUT_W-IN_W){1'b0}}};
            2'b11: ext_val = {sext[OUT_W-3:0], 2'b00};
            default: ext_val = '0;
        endcase
    end

    // Full buffer refuses a push even when the head is popping in the same cycle.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign extended  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = ext_val;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: default instance plus an IN_W=12, DEPTH=3 instance.
module tb_imm_extend_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_immediate;
    logic [1:0]  a_mode;
    logic [31:0] a_extended;
    logic [1:0]  a_count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [11:0] b_immediate;
    logic [1:0]  b_mode;
    logic [31:0] b_extended;
    logic [1:0]  b_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .immediate(a_immediate), .mode(a_mode), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .extended(a_extended), .count(a_count));

    imm_extend_pipe #(.IN_W(12), .OUT_W(32), .DEPTH(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .immediate(b_immediate), .mode(b_mode), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .extended(b_extended), .count(b_count));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: a pop happens at the next rising edge whenever valid && ready at the falling edge.
    always @(negedge clk) begin
        if (reset_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_out got %h expected none", a_extended);
            end else chk("a_out", a_extended, qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (reset_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_out got %h expected none", b_extended);
            end else chk("b_out", b_extended, qb.pop_front());
        end
    end

    task automatic push_a(input logic [15:0] imm, input logic [1:0] m, input logic [31:0] exp);
        a_immediate = imm; a_mode = m; a_in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (a_in_ready) begin
                qa.push_back(exp);
                @(posedge clk); #1;
                a_in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL a_push_timeout got no in_ready expected accept of %h", imm);
        a_in_valid = 1'b0;
    endtask

    task automatic push_b(input logic [11:0] imm, input logic [1:0] m, input logic [31:0] exp);
        b_immediate = imm; b_mode = m; b_in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (b_in_ready) begin
                qb.push_back(exp);
                @(posedge clk); #1;
                b_in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL b_push_timeout got no in_ready expected accept of %h", imm);
        b_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        a_out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!a_out_valid) break;
        end
        chk("a_drain_count", 32'(a_count), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain_b();
        b_out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!b_out_valid) break;
        end
        chk("b_drain_count", 32'(b_count), 32'd0);
        @(posedge clk); #1;
    endtask

    logic [15:0] v_imm [10] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                16'h7FFF, 16'h1234};
    logic [1:0]  v_mode[10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3};
    logic [31:0] v_exp [10] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFFFFFC,
                                32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                                32'h00007FFF, 32'h000048D0};

    initial begin
        reset_n = 1'b0;
        a_in_valid = 0; a_out_ready = 0; a_immediate = '0; a_mode = '0;
        b_in_valid = 0; b_out_ready = 0; b_immediate = '0; b_mode = '0;
        #1;
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_extended", a_extended, 32'd0);
        #21 reset_n = 1'b1;
        @(posedge clk); #1;

        // Mode table, consumer always ready
        a_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) push_a(v_imm[i], v_mode[i], v_exp[i]);
        drain_a();

        // Fill with backpressure, extra offer must be refused
        a_out_ready = 1'b0;
        push_a(16'h0001, 2'd0, 32'h00000001);
        push_a(16'h8000, 2'd1, 32'hFFFF8000);
        a_immediate = 16'h5555; a_mode = 2'd2; a_in_valid = 1'b1;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            chk("fill_count", 32'(a_count), 32'd2);
            chk("fill_in_ready", 32'(a_in_ready), 32'd0);
            chk("fill_hold_head", a_extended, 32'h00000001);
            chk("fill_out_valid", 32'(a_out_valid), 32'd1);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        drain_a();

        // Streaming: one push and one pop each cycle
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_mode = 2'd0;
        for (int i = 0; i < 8; i++) begin
            a_immediate = 16'h0010 + 16'(i);
            @(negedge clk);
            chk("stream_count", 32'(a_count), (i == 0) ? 32'd0 : 32'd1);
            chk("stream_in_ready", 32'(a_in_ready), 32'd1);
            qa.push_back(32'h00000010 + 32'(i));
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        drain_a();

        // Full plus pop: pop only, then push and pop together
        a_out_ready = 1'b0;
        push_a(16'h00A1, 2'd0, 32'h000000A1);
        push_a(16'hFFFE, 2'd3, 32'hFFFFFFF8);
        a_immediate = 16'h0C00; a_mode = 2'd2; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(negedge clk);
        chk("fullpop_in_ready", 32'(a_in_ready), 32'd0);
        @(posedge clk); #1;
        chk("fullpop_count1", 32'(a_count), 32'd1);
        @(negedge clk);
        chk("fullpop_in_ready2", 32'(a_in_ready), 32'd1);
        qa.push_back(32'h0C000000);
        @(posedge clk); #1;
        chk("fullpop_count2", 32'(a_count), 32'd1);
        a_in_valid = 1'b0;
        drain_a();

        // Reset mid-operation with two entries buffered
        a_out_ready = 1'b0;
        push_a(16'h1111, 2'd0, 32'h00001111);
        push_a(16'h2222, 2'd0, 32'h00002222);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_count", 32'(a_count), 32'd0);
        chk("midrst_out_valid", 32'(a_out_valid), 32'd0);
        chk("midrst_extended", a_extended, 32'd0);
        chk("midrst_in_ready", 32'(a_in_ready), 32'd1);
        qa.delete();
        @(posedge clk); #3 reset_n = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        push_a(16'h00AB, 2'd1, 32'h000000AB);
        drain_a();

        // Narrow, odd-depth instance: modes then fill to wrap pointers
        b_out_ready = 1'b1;
        push_b(12'h800, 2'd1, 32'hFFFFF800);
        push_b(12'h800, 2'd3, 32'hFFFFE000);
        push_b(12'h7FF, 2'd2, 32'h7FF00000);
        push_b(12'h123, 2'd0, 32'h00000123);
        drain_b();
        b_out_ready = 1'b0;
        push_b(12'h001, 2'd0, 32'h00000001);
        push_b(12'hFFF, 2'd1, 32'hFFFFFFFF);
        push_b(12'h400, 2'd3, 32'h00001000);
        @(negedge clk);
        chk("b_full_count", 32'(b_count), 32'd3);
        chk("b_full_in_ready", 32'(b_in_ready), 32'd0);
        chk("b_full_head", b_extended, 32'h00000001);
        @(posedge clk); #1;
        drain_b();
        b_out_ready = 1'b1;
        push_b(12'h0F0, 2'd0, 32'h000000F0);
        push_b(12'hABC, 2'd2, 32'hABC00000);
        drain_b();

        chk("a_queue_empty", 32'(qa.size()), 32'd0);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
